// File: rtl/servo_pkg.sv
// Shared servo definitions: nominal frame timing, angle range
// and the decoder state encoding.
package servo_pkg;

  localparam int unsigned PERIOD_NOM = 1800;
  localparam int unsigned MIN_HIGH   = 45;
  localparam int unsigned ANGLE_MAX  = 180;

  typedef enum logic [1:0] {
    ST_WAIT_RISE = 2'd0,
    ST_HIGH      = 2'd1,
    ST_LOW       = 2'd2
  } servo_state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus delay flop with edge detection.
// Edges are only reported once a real low level has been seen.
module edge_sync (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_fill;
  logic       r_armed;

  // r_fill marks when s2 holds a real sample rather than
  // the reset value, so a line held high across reset
  // cannot masquerade as a rising edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_s1   <= d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_s2)
        r_armed <= 1'b1;
    end
  end

  assign level = r_s2;
  assign rise  = r_armed & r_s2 & ~r_s3;
  assign fall  = r_armed & ~r_s2 & r_s3;

endmodule

// File: rtl/servo_pwm_decode.sv
// Servo PWM decoder: measures high width and period in ticks
// and maps the width to an angle with range/period checks.
module servo_pwm_decode #(
  parameter int unsigned PERIOD_NOM = servo_pkg::PERIOD_NOM,
  parameter int unsigned MIN_HIGH   = servo_pkg::MIN_HIGH,
  parameter int unsigned ANGLE_MAX  = servo_pkg::ANGLE_MAX,
  parameter int unsigned PER_TOL    = 90,
  parameter int unsigned TIMEOUT    = 3600
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        tick,
  input  logic        pwm_in,
  output logic [15:0] angle,
  output logic [15:0] high_cnt,
  output logic [15:0] period,
  output logic        valid,
  output logic        err_range,
  output logic        err_period,
  output logic        err_timeout
);

  import servo_pkg::*;

  localparam logic [15:0] LP_MIN  = 16'(MIN_HIGH);
  localparam logic [15:0] LP_AMAX = 16'(ANGLE_MAX);
  localparam logic [15:0] LP_MAXH =
    16'(MIN_HIGH + ANGLE_MAX);
  localparam logic [15:0] LP_PLO =
    16'((PERIOD_NOM > PER_TOL) ?
        (PERIOD_NOM - PER_TOL) : 32'd0);
  localparam logic [15:0] LP_PHI =
    16'(PERIOD_NOM + PER_TOL);
  localparam logic [15:0] LP_TMO =
    16'((TIMEOUT > 32'd65535) ? 32'd65535 : TIMEOUT);

  logic         w_level;
  logic         w_rise;
  logic         w_fall;

  servo_state_e r_state;
  servo_state_e w_state_nx;
  logic [15:0]  r_hi_acc;
  logic [15:0]  r_per_acc;

  logic         w_clr;
  logic         w_hi_inc;
  logic         w_per_inc;
  logic         w_pub;
  logic         w_tmo;
  logic         w_below;
  logic         w_above;
  logic [15:0]  w_angle;
  logic         w_erange;
  logic         w_eper;

  logic [15:0]  r_angle;
  logic [15:0]  r_high;
  logic [15:0]  r_period;
  logic         r_valid;
  logic         r_erange;
  logic         r_eper;
  logic         r_etmo;

  edge_sync u_sync (
    .clk   (clk),
    .nrst  (nrst),
    .d     (pwm_in),
    .level (w_level),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  // Edges take priority over a same-cycle tick, so that
  // tick is simply not counted.
  always_comb begin
    w_state_nx = r_state;
    w_clr      = 1'b0;
    w_hi_inc   = 1'b0;
    w_per_inc  = 1'b0;
    w_pub      = 1'b0;
    w_tmo      = 1'b0;
    unique case (r_state)
      ST_WAIT_RISE: begin
        if (w_rise) begin
          w_clr      = 1'b1;
          w_state_nx = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (r_per_acc >= LP_TMO) begin
          w_tmo      = 1'b1;
          w_state_nx = ST_WAIT_RISE;
        end else if (w_fall) begin
          w_state_nx = ST_LOW;
        end else if (tick && w_level) begin
          w_hi_inc  = 1'b1;
          w_per_inc = 1'b1;
        end
      end
      ST_LOW: begin
        if (r_per_acc >= LP_TMO) begin
          w_tmo      = 1'b1;
          w_state_nx = ST_WAIT_RISE;
        end else if (w_rise) begin
          w_pub      = 1'b1;
          w_clr      = 1'b1;
          w_state_nx = ST_HIGH;
        end else if (tick) begin
          w_per_inc = 1'b1;
        end
      end
      default: w_state_nx = ST_WAIT_RISE;
    endcase
  end

  assign w_below = (r_hi_acc < LP_MIN);
  assign w_above = (r_hi_acc > LP_MAXH);

  always_comb begin
    w_angle  = 16'd0;
    w_erange = 1'b0;
    unique case (1'b1)
      w_below: begin
        w_angle  = 16'd0;
        w_erange = 1'b1;
      end
      w_above: begin
        w_angle  = LP_AMAX;
        w_erange = 1'b1;
      end
      default: w_angle = r_hi_acc - LP_MIN;
    endcase
  end

  assign w_eper = (r_per_acc < LP_PLO) ||
                  (r_per_acc > LP_PHI);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_state <= ST_WAIT_RISE;
    else
      r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hi_acc  <= 16'd0;
      r_per_acc <= 16'd0;
    end else if (w_clr) begin
      r_hi_acc  <= 16'd0;
      r_per_acc <= 16'd0;
    end else begin
      if (w_hi_inc)
        r_hi_acc <= sat_inc(r_hi_acc);
      if (w_per_inc)
        r_per_acc <= sat_inc(r_per_acc);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_angle  <= 16'd0;
      r_high   <= 16'd0;
      r_period <= 16'd0;
      r_valid  <= 1'b0;
      r_erange <= 1'b0;
      r_eper   <= 1'b0;
      r_etmo   <= 1'b0;
    end else begin
      r_valid <= w_pub;
      if (w_pub) begin
        r_angle  <= w_angle;
        r_high   <= r_hi_acc;
        r_period <= r_per_acc;
        r_erange <= w_erange;
        r_eper   <= w_eper;
        r_etmo   <= 1'b0;
      end else if (w_tmo) begin
        r_etmo <= 1'b1;
      end
    end
  end

  assign angle       = r_angle;
  assign high_cnt    = r_high;
  assign period      = r_period;
  assign valid       = r_valid;
  assign err_range   = r_erange;
  assign err_period  = r_eper;
  assign err_timeout = r_etmo;

endmodule

// File: tb/tb_servo_pwm_decode.sv
// Directed bench for servo_pwm_decode: frames are built from
// two-clock tick slots so expected counts are exact.
module tb_servo_pwm_decode;

  logic        clk    = 1'b0;
  logic        nrst   = 1'b0;
  logic        tick   = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] angle;
  logic [15:0] high_cnt;
  logic [15:0] period;
  logic        valid;
  logic        err_range;
  logic        err_period;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int vcyc     = -1;
  int rise_k   = 0;
  int chg_bad  = 0;
  bit tick_even = 1'b0;

  logic [15:0] p_angle;
  logic [15:0] p_high;
  logic [15:0] p_period;
  logic        p_er;
  logic        p_ep;

  servo_pwm_decode dut (
    .clk         (clk),
    .nrst        (nrst),
    .tick        (tick),
    .pwm_in      (pwm_in),
    .angle       (angle),
    .high_cnt    (high_cnt),
    .period      (period),
    .valid       (valid),
    .err_range   (err_range),
    .err_period  (err_period),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count valid pulses; flag any published output that moves
  // outside a valid cycle while out of reset.
  always @(negedge clk) begin
    if (valid) begin
      vcnt = vcnt + 1;
      vcyc = cyc;
    end else if (nrst &&
                 (angle !== p_angle || high_cnt !== p_high ||
                  period !== p_period ||
                  err_range !== p_er ||
                  err_period !== p_ep)) begin
      chg_bad = chg_bad + 1;
    end
    p_angle  = angle;
    p_high   = high_cnt;
    p_period = period;
    p_er     = err_range;
    p_ep     = err_period;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic slot(input bit lvl);
    @(negedge clk);
    #1;
    if (lvl && !pwm_in) rise_k = cyc + 1;
    pwm_in = lvl;
    tick   = tick_even;
    @(negedge clk);
    #1;
    tick = ~tick_even;
  endtask

  task automatic slots(input int n, input bit lvl);
    repeat (n) slot(lvl);
  endtask

  task automatic frame(input int h, input int p);
    slots(h, 1'b1);
    slots(p - h, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_angle", 32'(angle), 0);
    chk("rst_high", 32'(high_cnt), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_erange", 32'(err_range), 0);
    chk("rst_eper", 32'(err_period), 0);
    chk("rst_etmo", 32'(err_timeout), 0);
    #1 nrst = 1'b1;
    slots(20, 1'b0);

    repeat (3) frame(90, 1800);
    chk("f3_vcnt", 32'(vcnt), 2);
    chk("f3_angle", 32'(angle), 45);
    chk("f3_high", 32'(high_cnt), 90);
    chk("f3_period", 32'(period), 1800);
    chk("f3_erange", 32'(err_range), 0);
    chk("f3_eper", 32'(err_period), 0);
    chk("f3_etmo", 32'(err_timeout), 0);
    chk("latency", 32'(vcyc - rise_k), 2);

    frame(45, 1800);
    frame(225, 1800);
    chk("h45_angle", 32'(angle), 0);
    chk("h45_high", 32'(high_cnt), 45);
    chk("h45_erange", 32'(err_range), 0);
    frame(20, 1800);
    chk("h225_angle", 32'(angle), 180);
    chk("h225_high", 32'(high_cnt), 225);
    chk("h225_erange", 32'(err_range), 0);
    frame(300, 1800);
    chk("h20_angle", 32'(angle), 0);
    chk("h20_high", 32'(high_cnt), 20);
    chk("h20_erange", 32'(err_range), 1);
    frame(90, 1600);
    chk("h300_angle", 32'(angle), 180);
    chk("h300_high", 32'(high_cnt), 300);
    chk("h300_erange", 32'(err_range), 1);
    chk("h300_eper", 32'(err_period), 0);
    frame(90, 1800);
    chk("p1600_angle", 32'(angle), 45);
    chk("p1600_period", 32'(period), 1600);
    chk("p1600_eper", 32'(err_period), 1);
    chk("p1600_erange", 32'(err_range), 0);

    slots(3590, 1'b1);
    chk("stuck_pre_etmo", 32'(err_timeout), 0);
    chk("p1800_period", 32'(period), 1800);
    chk("p1800_eper", 32'(err_period), 0);
    slots(20, 1'b1);
    chk("stuck_etmo", 32'(err_timeout), 1);
    chk("stuck_vcnt", 32'(vcnt), 9);
    chk("stuck_angle", 32'(angle), 45);
    chk("stuck_high", 32'(high_cnt), 90);
    chk("stuck_period", 32'(period), 1800);

    slots(10, 1'b0);
    frame(90, 1800);
    frame(90, 1800);
    chk("rec_vcnt", 32'(vcnt), 10);
    chk("rec_etmo", 32'(err_timeout), 0);
    chk("rec_high", 32'(high_cnt), 90);
    chk("rec_period", 32'(period), 1800);
    chk("rec_angle", 32'(angle), 45);

    slots(30, 1'b1);
    chk("pre_rst_vcnt", 32'(vcnt), 11);
    @(negedge clk);
    #1 nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_angle", 32'(angle), 0);
    chk("mid_rst_high", 32'(high_cnt), 0);
    chk("mid_rst_period", 32'(period), 0);
    chk("mid_rst_eper", 32'(err_period), 0);
    #1 nrst = 1'b1;
    tick_even = 1'b1;
    slots(60, 1'b1);
    slots(1740, 1'b0);
    chk("rel_vcnt", 32'(vcnt), 11);
    frame(90, 1800);
    chk("r1_vcnt", 32'(vcnt), 11);
    chk("r1_angle", 32'(angle), 0);
    frame(90, 1800);
    chk("r2_vcnt", 32'(vcnt), 12);
    chk("r2_high", 32'(high_cnt), 89);
    chk("r2_period", 32'(period), 1798);
    chk("r2_angle", 32'(angle), 44);
    chk("r2_eper", 32'(err_period), 0);
    chk("r2_erange", 32'(err_range), 0);
    chk("stable_outputs", 32'(chg_bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decode.md
SERVO_PWM_DECODE -- requirements
Module: servo_pwm_decode

Interface
REQ-001 Parameter PERIOD_NOM, default 1800, nominal frame length in ticks (20 ms at 90 kHz).
REQ-002 Parameter MIN_HIGH, default 45, high width in ticks that encodes angle 0.
REQ-003 Parameter ANGLE_MAX, default 180, highest legal angle.
REQ-004 Parameter PER_TOL, default 90, allowed period deviation in ticks.
REQ-005 Parameter TIMEOUT, default 3600, tick count with no rising edge before the frame is abandoned.
REQ-006 Port clk  input  1  system clock; the block's only clock.
REQ-007 Port nrst  input  1  reset, asynchronous, active-low.
REQ-008 Port tick  input  1  single-cycle count enable at 90 kHz.
REQ-009 Port pwm_in  input  1  asynchronous servo PWM input.
REQ-010 Port angle  output  16  decoded angle, 0..ANGLE_MAX.
REQ-011 Port high_cnt  output  16  last measured high width, in ticks.
REQ-012 Port period  output  16  last measured rise-to-rise period, in ticks.
REQ-013 Port valid  output  1  single-cycle pulse that marks a new measurement.
REQ-014 Port err_range  output  1  last high width fell outside [MIN_HIGH, MIN_HIGH+ANGLE_MAX].
REQ-015 Port err_period  output  1  last period fell outside PERIOD_NOM±PER_TOL.
REQ-016 Port err_timeout  output  1  sticky flag: no rising edge within TIMEOUT ticks.

Function
REQ-017 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) and then a delay flop (s3); rise = s2 & ~s3, fall = ~s2 & s3; edges are evaluated every clk cycle, not only on ticks.
REQ-018 The FSM SHALL have three states: WAIT_RISE (after reset/timeout), HIGH and LOW.
REQ-019 In WAIT_RISE, a rise SHALL clear hi_acc and per_acc to 0 and go to HIGH, with no publish, so a partial first frame is discarded.
REQ-020 In HIGH, each tick SHALL increment hi_acc and per_acc, both saturating at 16'hFFFF.
REQ-021 In HIGH, a fall SHALL go to LOW, and hi_acc SHALL hold its value.
REQ-022 In LOW, each tick SHALL increment per_acc only.
REQ-023 In LOW, a rise SHALL publish high_cnt=hi_acc and period=per_acc, update angle/err_range/err_period, pulse valid for one cycle, clear err_timeout, clear both accumulators to 0, and go to HIGH.
REQ-024 When an edge and a tick occur in the same cycle, the edge SHALL win: accumulators load 0 and that tick is dropped.
REQ-025 When per_acc reaches TIMEOUT in HIGH or LOW, the block SHALL set err_timeout, go to WAIT_RISE, skip valid, and hold the published outputs.
REQ-026 Angle mapping: if high < MIN_HIGH, angle=0 and err_range=1.
REQ-027 Angle mapping: if high > MIN_HIGH+ANGLE_MAX, angle=ANGLE_MAX and err_range=1.
REQ-028 Angle mapping: otherwise, angle=high-MIN_HIGH and err_range=0; the subtraction is unsigned 16-bit and is guarded so it cannot wrap.
REQ-029 err_period SHALL be 1 iff period < PERIOD_NOM-PER_TOL or period > PERIOD_NOM+PER_TOL.
REQ-030 Latency: valid and all published outputs SHALL be registered and update on the 3rd clk rising edge after the pwm_in rise, given that pwm_in meets setup.
REQ-031 angle, high_cnt, period, err_range and err_period SHALL change only in the valid cycle.

Reset
REQ-032 While nrst=0, the block SHALL force all outputs to 0, s1/s2/s3 to 0, both accumulators to 0, and the state to WAIT_RISE.
REQ-033 A reset asserted mid-frame SHALL abandon the frame, and the first valid after release SHALL require two rises.
REQ-034 If pwm_in is high at reset release, the block SHALL see no rise until pwm_in goes low and then high.

Structure
REQ-035 Package servo_pkg SHALL hold PERIOD_NOM, MIN_HIGH, ANGLE_MAX and the FSM state enum, shared with the servo PWM generator.
REQ-036 The synchronizer and edge detect SHALL be a single sub-module, edge_sync (ports: clk, nrst, d, level, rise, fall).
REQ-037 The FSM, accumulators and mapping SHALL stay in servo_pwm_decode.

Verification
REQ-038 Scenario: 3 frames, high=90 ticks, period=1800 -> 2 valid pulses, angle=45, high_cnt=90, period=1800, all errors 0.
REQ-039 Scenario: high=45, then high=225, period=1800 -> angle=0, then angle=180, err_range=0 for both.
REQ-040 Scenario: high=20, then high=300 -> angle=0 with err_range=1, then angle=180 with err_range=1.
REQ-041 Scenario: period=1600, high=90 -> angle=45 and err_period=1; a following frame with period=1800 -> err_period=0.
REQ-042 Scenario: pwm_in stuck high for 3600 ticks -> err_timeout=1, no valid, outputs unchanged; then 2 good frames -> valid, err_timeout=0.
REQ-043 Scenario: nrst pulsed mid-HIGH, plus a pwm_in edge coincident with tick -> all outputs 0, the first valid only after the 2nd rise, and the coincident edge tick not counted (high_cnt exact).
